mips_prog_loader: RTL and testbench

Byte-stream program loader for the pipelined MIPS32 core. It receives a framed program image over a valid/ready byte interface and writes the instruction words into the core's instruction/data memory. While loading it holds the core halted. After a good checksum it issues a release pulse that clears PC, HALTED and TAKEN_BRANCH. It sits between the host link (UART/debug bridge) and the core's memory write port, and replaces hierarchical memory preloading in system-level runs.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/prog_word_assembler.sv | 43 ++++
 rtl/mips_prog_loader.sv | 139 +++++++++++++
 tb/tb_mips_prog_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 program loader: FSM states, word width,
// HALT opcode and frame layout constants.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam logic [5:0] HALT_OP = 6'h3f;

    // Frame = 2 header bytes (big-endian word count), 4*N payload bytes, 1 checksum byte.
    localparam int HDR_LEN = 2;
    localparam int CHK_LEN = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_WORD,
        ST_CHK,
        ST_RELEASE,
        ST_FAIL
    } state_t;

    function automatic int frame_bytes(input int n_words);
        return HDR_LEN + 4 * n_words + CHK_LEN;
    endfunction

endpackage

// File: rtl/prog_word_assembler.sv
// Collects payload bytes MSB-first into a 32-bit word and emits a registered
// one-cycle memory write when the fourth byte of a word arrives.
module prog_word_assembler
    import mips_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift,
    input  logic [7:0]        byte_in,
    input  logic [1:0]        byte_cnt,
    input  logic              word_ready,
    input  logic [ADDR_W-1:0] word_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata
);

    logic [WORD_W-1:0] shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (shift) begin
                // The first byte of each word starts from a clean register.
                shreg <= (byte_cnt == 2'd0) ? {{(WORD_W-8){1'b0}}, byte_in}
                                            : {shreg[WORD_W-9:0], byte_in};
            end
            if (word_ready) begin
                mem_we    <= 1'b1;
                mem_addr  <= word_addr;
                mem_wdata <= {shreg[WORD_W-9:0], byte_in};
            end
        end
    end

endmodule

// File: rtl/mips_prog_loader.sv
// Framed byte-stream program loader: writes instruction words into core memory,
// holds the core halted while loading and releases it after a good checksum.
module mips_prog_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_hold,
    output logic              core_release,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t      state;
    logic [7:0]  count_hi;
    logic [15:0] count_n;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [7:0]  chk;

    logic        accept;
    logic        shift;
    logic        word_ready;
    logic [15:0] hdr_n;

    assign accept     = in_valid && in_ready;
    assign shift      = accept && (state == ST_WORD);
    assign word_ready = shift && (byte_idx == 2'd3);
    assign hdr_n      = {count_hi, in_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b0;
            core_hold    <= 1'b1;
            core_release <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            count_hi     <= '0;
            count_n      <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            chk          <= '0;
        end else begin
            // NOTE: every register here uses <= so all updates see the pre-edge
            // values; blocking assignments would make the order of statements matter.
            core_release <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_HDR0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        core_hold <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        chk       <= '0;
                        byte_idx  <= '0;
                        word_idx  <= '0;
                    end
                end
                ST_HDR0: begin
                    if (accept) begin
                        count_hi <= in_data;
                        state    <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (accept) begin
                        count_n <= hdr_n;
                        if (hdr_n == 16'd0 || 32'(hdr_n) > MAX_WORDS) begin
                            state    <= ST_FAIL;
                            err      <= 1'b1;
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                        end else begin
                            state <= ST_WORD;
                        end
                    end
                end
                ST_WORD: begin
                    if (accept) begin
                        chk      <= chk ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            word_idx <= word_idx + 16'd1;
                            if (word_idx == count_n - 16'd1) state <= ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == chk) begin
                            state        <= ST_RELEASE;
                            core_release <= 1'b1;
                            core_hold    <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            // Core stays halted until a later load succeeds.
                            state <= ST_FAIL;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_RELEASE: state <= ST_IDLE;
                ST_FAIL:    state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    prog_word_assembler #(.ADDR_W(ADDR_W)) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift      (shift),
        .byte_in    (in_data),
        .byte_cnt   (byte_idx),
        .word_ready (word_ready),
        .word_addr  (word_idx[ADDR_W-1:0]),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata)
    );

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader: directed and random frames compared
// against a frame/write model built from the frame format rules.
module tb_mips_prog_loader;
    import mips_pkg::*;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_hold;
    logic              core_release;
    logic              busy;
    logic              done;
    logic              err;

    mips_prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_hold    (core_hold),
        .core_release (core_release),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int rel_cnt    = 0;
    int lat;

    logic [ADDR_W-1:0] obs_addr[$];
    logic [31:0]       obs_data[$];
    logic [31:0]       prog[$];

    always @(posedge clk) cyc++;

    // Write/release monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
        end
        if (core_release === 1'b1) rel_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},     in_ready,     1'b0);
        check({tag, "_mem_we"},       mem_we,       1'b0);
        check({tag, "_mem_addr"},     mem_addr,     '0);
        check({tag, "_mem_wdata"},    mem_wdata,    '0);
        check({tag, "_core_hold"},    core_hold,    1'b1);
        check({tag, "_core_release"}, core_release, 1'b0);
        check({tag, "_busy"},         busy,         1'b0);
        check({tag, "_done"},         done,         1'b0);
        check({tag, "_err"},          err,          1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit throttle, input bit pulse_start);
        int  guard = 0;
        bit  sent  = 0;
        while (!sent && guard < 500) begin
            @(negedge clk);
            start = pulse_start && (guard == 0);
            if (throttle && $urandom_range(0, 99) >= 30) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                if (in_ready) begin
                    @(posedge clk);
                    sent = 1;
                end
            end
            guard++;
        end
        if (!sent) begin
            compared++;
            mismatched++;
            $error("FAIL send_timeout: observed in_ready=%0b expected 1", in_ready);
        end
    endtask

    // Builds the frame for prog[] from the format rules and streams it.
    task automatic run_load(input string tag, input logic [15:0] n_hdr, input logic [7:0] chk_xor,
                            input bit throttle, input int start_at, output int latency);
        logic [7:0] bytes[$];
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        bit         hdr_ok;
        bit         good;
        int         t0;
        int         t1;
        hdr_ok = (n_hdr != 16'd0) && (int'(n_hdr) <= MAX_WORDS);
        good   = hdr_ok && (chk_xor == 8'h00);
        bytes.push_back(n_hdr[15:8]);
        bytes.push_back(n_hdr[7:0]);
        if (hdr_ok) begin
            foreach (prog[i]) begin
                for (int k = 3; k >= 0; k--) begin
                    b = prog[i][8*k +: 8];
                    x ^= b;
                    bytes.push_back(b);
                end
            end
            bytes.push_back(x ^ chk_xor);
        end
        obs_addr.delete();
        obs_data.delete();
        rel_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
        foreach (bytes[i]) send_byte(bytes[i], throttle, i == start_at);
        #1;
        t1      = cyc;
        latency = t1 - t0 + 1;
        if (!hdr_ok) begin
            check({tag, "_hdr_err"},  err,  1'b1);
            check({tag, "_hdr_busy"}, busy, 1'b0);
        end else begin
            check({tag, "_release_edge"}, core_release, good);
            check({tag, "_done_edge"},    done,         good);
            check({tag, "_err_edge"},     err,          !good);
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic verify(input string tag, input bit good, input int n_wr);
        check({tag, "_nwrites"}, obs_addr.size(), n_wr);
        for (int i = 0; i < n_wr && i < obs_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), obs_addr[i], i);
            check($sformatf("%s_data%0d", tag, i), obs_data[i], prog[i]);
        end
        check({tag, "_releases"},  rel_cnt,   good ? 1 : 0);
        check({tag, "_core_hold"}, core_hold, !good);
        check({tag, "_done"},      done,      good);
        check({tag, "_err"},       err,       !good);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_in_ready"},  in_ready,  1'b0);
    endtask

    task automatic load_golden();
        prog.delete();
        prog.push_back(32'h2801000a);
        prog.push_back(32'h28020014);
        prog.push_back(32'h28030019);
        prog.push_back(32'h0ce77800);
        prog.push_back(32'h0ce77800);
        prog.push_back(32'h00222000);
        prog.push_back(32'h0ce77800);
        prog.push_back(32'h00832800);
        prog.push_back(32'hfc000000);
    endtask

    initial begin
        int n;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1'b0);

        load_golden();
        run_load("good", 16'd9, 8'h00, 1'b0, -1, lat);
        verify("good", 1'b1, 9);
        check("good_latency", lat, frame_bytes(9) + 1);
        if (obs_data.size() == 9) check("good_halt_op", obs_data[8][31:26], HALT_OP);

        run_load("badchk", 16'd9, 8'h01, 1'b0, -1, lat);
        verify("badchk", 1'b0, 9);

        run_load("n0", 16'd0, 8'h00, 1'b0, -1, lat);
        verify("n0", 1'b0, 0);

        run_load("nmax1", 16'(MAX_WORDS + 1), 8'h00, 1'b0, -1, lat);
        verify("nmax1", 1'b0, 0);

        run_load("throttled", 16'd9, 8'h00, 1'b1, -1, lat);
        verify("throttled", 1'b1, 9);

        run_load("midstart", 16'd9, 8'h00, 1'b0, 20, lat);
        verify("midstart", 1'b1, 9);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 24);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back($urandom);
            run_load($sformatf("rand%0d", r), 16'(n), 8'h00, r[0], -1, lat);
            verify($sformatf("rand%0d", r), 1'b1, n);
            if (!r[0]) check($sformatf("rand%0d_latency", r), lat, frame_bytes(n) + 1);
        end

        // Abort after 6 payload bytes: only word 0 was complete before reset.
        load_golden();
        obs_addr.delete();
        obs_data.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h09, 1'b0, 1'b0);
        for (int k = 3; k >= 0; k--) send_byte(prog[0][8*k +: 8], 1'b0, 1'b0);
        send_byte(prog[1][31:24], 1'b0, 1'b0);
        send_byte(prog[1][23:16], 1'b0, 1'b0);
        check("abort_busy_before", busy, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        repeat (3) @(negedge clk);
        check("abort_nwrites", obs_addr.size(), 1);
        check("abort_mem_we_low", mem_we, 1'b0);
        rst_n = 1'b1;
        run_load("after_abort", 16'd9, 8'h00, 1'b0, -1, lat);
        verify("after_abort", 1'b1, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
